// File: rtl/led_ctrl_pkg.sv
// Shared types and default sizing for the
// memory port scheduler and its picker.
package led_ctrl_pkg;

  localparam int DEF_ADDRESS_WIDTH = 14;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_PERIPHERALS   = 2;
  localparam int DEF_BURST_MAX     = 8;
  localparam int DEF_READ_LATENCY  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin search: first set request at or
// after the pointer, scanning upward with wrap.
module rr_priority_picker
  import led_ctrl_pkg::*;
#(
  parameter int N = DEF_PERIPHERALS,
  localparam int PW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [PW-1:0] j;

  // Scan N positions from ptr_i; keep the first hit.
  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[j]) begin
        pick_o[j] = 1'b1;
        idx_o     = j;
        valid_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Round-robin burst arbiter in front of a single
// memory port, with in-order read-return tracking.
module mem_port_scheduler
  import led_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int PERIPHERALS   = DEF_PERIPHERALS,
  parameter int BURST_MAX     = DEF_BURST_MAX,
  parameter int READ_LATENCY  = DEF_READ_LATENCY
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [PERIPHERALS-1:0]             req,
  input  logic [PERIPHERALS-1:0]             wr,
  input  logic [ADDRESS_WIDTH*PERIPHERALS-1:0] address,
  input  logic [DATA_WIDTH*PERIPHERALS-1:0]  data_in,
  output logic [PERIPHERALS-1:0]             gnt,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [ADDRESS_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic [PERIPHERALS-1:0]             data_out_ready
);

  localparam int PW = idx_width(PERIPHERALS);
  localparam int CW = idx_width(BURST_MAX);

  sched_state_e           state_q;
  logic [PERIPHERALS-1:0] gnt_q;
  logic [PW-1:0]          gidx_q;
  logic [PW-1:0]          ptr_q;
  logic [CW-1:0]          cnt_q;

  logic [PW-1:0]          nxt_ptr;
  logic [PW-1:0]          sel_ptr;
  logic [PERIPHERALS-1:0] pick;
  logic [PW-1:0]          pick_idx;
  logic                   pick_vld;
  logic                   in_grant;
  logic                   accept;
  logic                   beat_wr;
  logic                   last_beat;
  logic                   rel;

  assign in_grant  = (state_q == ST_GRANT);
  assign accept    = in_grant && req[gidx_q];
  assign beat_wr   = wr[gidx_q];
  assign last_beat = accept && (cnt_q == CW'(BURST_MAX - 1));
  assign rel       = in_grant && (!req[gidx_q] || last_beat);
  assign nxt_ptr   = (gidx_q == PW'(PERIPHERALS - 1)) ? '0
                   : gidx_q + 1'b1;
  // On release the search starts just past the grantee,
  // which leaves the grantee itself as lowest priority.
  assign sel_ptr   = in_grant ? nxt_ptr : ptr_q;

  rr_priority_picker #(
    .N(PERIPHERALS)
  ) u_pick (
    .req_i  (req),
    .ptr_i  (sel_ptr),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .valid_o(pick_vld)
  );

  // Grant FSM: pick, count beats, hand over without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q <= ST_GRANT;
            gnt_q   <= pick;
            gidx_q  <= pick_idx;
            cnt_q   <= '0;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            ptr_q <= nxt_ptr;
            cnt_q <= '0;
            if (pick_vld) begin
              gnt_q  <= pick;
              gidx_q <= pick_idx;
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
            end
          end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic                    mem_en_q;
  logic                    mem_wr_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;

  // Register the accepted beat onto the memory port.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= accept;
      mem_wr_q <= accept && beat_wr;
      if (accept) begin
        mem_addr_q  <= address[gidx_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        mem_wdata_q <= data_in[gidx_q*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  logic [READ_LATENCY-1:0]         rv_q;
  logic [READ_LATENCY-1:0][PW-1:0] rid_q;
  logic [PERIPHERALS-1:0]          rdy_q;

  // Carry read owner IDs until the memory answers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rv_q  <= '0;
      rid_q <= '0;
      rdy_q <= '0;
    end else begin
      rv_q[0]  <= accept && !beat_wr;
      rid_q[0] <= gidx_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        rv_q[k]  <= rv_q[k-1];
        rid_q[k] <= rid_q[k-1];
      end
      rdy_q <= rv_q[READ_LATENCY-1]
             ? (PERIPHERALS'(1) << rid_q[READ_LATENCY-1])
             : '0;
    end
  end

  assign gnt            = gnt_q;
  assign mem_en         = mem_en_q;
  assign mem_wr         = mem_wr_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign data_out_ready = rdy_q;
  assign data_out       = (|rdy_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler with a
// fixed-latency memory model behind the port.
module tb_mem_port_scheduler;

  localparam int RL = 2;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [13:0] a0, a1;
  logic [15:0] d0, d1;
  logic [27:0] address;
  logic [31:0] data_in;
  logic [1:0]  gnt;
  logic        mem_en;
  logic        mem_wr;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] data_out;
  logic [1:0]  data_out_ready;

  int errors = 0;
  int checks = 0;

  assign address = {a1, a0};
  assign data_in = {d1, d0};

  mem_port_scheduler #(
    .ADDRESS_WIDTH(14),
    .DATA_WIDTH(16),
    .PERIPHERALS(2),
    .BURST_MAX(8),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .wr(wr),
    .address(address),
    .data_in(data_in),
    .gnt(gnt),
    .mem_en(mem_en),
    .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .data_out(data_out),
    .data_out_ready(data_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f(input logic [13:0] a);
    return {2'b00, a} ^ 16'hA5A5;
  endfunction

  // Memory answers RL cycles after the strobe.
  logic [15:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? f(mem_addr) : 16'hDEAD;
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[RL-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req = '0; wr = '0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 2'b11; wr = 2'b11;
    a0 = 14'h0abc; a1 = 14'h0def;
    d0 = 16'h1111; d1 = 16'h2222;
    step();
    step();
    checks++;
    if (gnt !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got %b want 00", gnt);
    end
    checks++;
    if ({mem_en, mem_wr} !== 2'b00) begin
      errors++; $display("FAIL reset_en_wr got %b want 00", {mem_en, mem_wr});
    end
    checks++;
    if (mem_addr !== 14'h0) begin
      errors++; $display("FAIL reset_addr got %h want 0", mem_addr);
    end
    checks++;
    if (mem_wdata !== 16'h0) begin
      errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata);
    end
    checks++;
    if (data_out !== 16'h0 || data_out_ready !== 2'b00) begin
      errors++; $display("FAIL reset_dout got %h/%b want 0/00", data_out, data_out_ready);
    end
    checks++;
    if (dut.ptr_q !== 1'b0) begin
      errors++; $display("FAIL reset_ptr got %b want 0", dut.ptr_q);
    end
  endtask

  task automatic test_single_read();
    int nen, nrdy, fen, frdy;
    nen = 0; nrdy = 0; fen = -1; frdy = -1;
    reset_dut();
    req = 2'b01; wr = 2'b00; a0 = 14'h0010;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) begin
        checks++;
        if (gnt !== 2'b01) begin
          errors++; $display("FAIL sr_gnt_on got %b want 01", gnt);
        end
      end
      if (c == 5) begin
        checks++;
        if (gnt !== 2'b00) begin
          errors++; $display("FAIL sr_gnt_off got %b want 00", gnt);
        end
      end
      if (mem_en) begin
        nen++;
        if (fen < 0) fen = c;
        checks++;
        if (mem_addr !== 14'h0010 || mem_wr !== 1'b0) begin
          errors++; $display("FAIL sr_beat c=%0d got %h/%b want 0010/0", c, mem_addr, mem_wr);
        end
      end
      if (data_out_ready !== 2'b00) begin
        nrdy++;
        if (frdy < 0) frdy = c;
        checks++;
        if (data_out_ready !== 2'b01 || data_out !== f(14'h0010)) begin
          errors++; $display("FAIL sr_ret c=%0d got %b/%h want 01/%h", c, data_out_ready, data_out, f(14'h0010));
        end
      end
      if (c == 4) req = 2'b00;
    end
    checks++;
    if (nen != 3 || fen != 2) begin
      errors++; $display("FAIL sr_en_count got %0d@%0d want 3@2", nen, fen);
    end
    checks++;
    if (nrdy != 3 || frdy != 4) begin
      errors++; $display("FAIL sr_rdy_count got %0d@%0d want 3@4", nrdy, frdy);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp;
    int nen;
    nen = 0;
    reset_dut();
    req = 2'b11; wr = 2'b00; a0 = 14'h0001; a1 = 14'h0002;
    for (int c = 1; c <= 40; c++) begin
      step();
      exp = (((c - 1) / 8) % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (gnt !== exp) begin
        errors++; $display("FAIL alt_gnt c=%0d got %b want %b", c, gnt, exp);
      end
      if (c >= 2 && mem_en === 1'b1) nen++;
    end
    checks++;
    if (nen != 39) begin
      errors++; $display("FAIL alt_en_count got %0d want 39", nen);
    end
    req = 2'b00;
  endtask

  task automatic test_sole_requester();
    int nen, nrdy;
    nen = 0; nrdy = 0;
    reset_dut();
    req = 2'b10; wr = 2'b10; a1 = 14'h0aaa; d1 = 16'h5555;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (c <= 21) begin
        checks++;
        if (gnt !== 2'b10) begin
          errors++; $display("FAIL sole_gnt c=%0d got %b want 10", c, gnt);
        end
      end
      if (c == 22) begin
        checks++;
        if (gnt !== 2'b00) begin
          errors++; $display("FAIL sole_release got %b want 00", gnt);
        end
      end
      if (c >= 2 && c <= 21) begin
        checks++;
        if ({mem_en, mem_wr} !== 2'b11 || mem_wdata !== 16'h5555) begin
          errors++; $display("FAIL sole_beat c=%0d got %b/%h want 11/5555", c, {mem_en, mem_wr}, mem_wdata);
        end
      end
      if (mem_en === 1'b1) nen++;
      if (data_out_ready !== 2'b00) nrdy++;
      if (c == 21) req = 2'b00;
    end
    checks++;
    if (nen != 20) begin
      errors++; $display("FAIL sole_en_count got %0d want 20", nen);
    end
    checks++;
    if (nrdy != 0) begin
      errors++; $display("FAIL sole_write_ready got %0d want 0", nrdy);
    end
  endtask

  task automatic test_interleave();
    logic [5:0]  pat;
    logic [1:0]  erdy;
    logic [13:0] eaddr;
    int b;
    pat = 6'b100101;
    reset_dut();
    req = 2'b01; wr = 2'b00; a0 = 14'h0005; d0 = 16'h1234;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c >= 2 && c <= 7) begin
        b = c - 1;
        eaddr = pat[b-1] ? 14'h0005 : 14'(14'h0100 + b);
        checks++;
        if (mem_en !== 1'b1 || mem_wr !== pat[b-1] || mem_addr !== eaddr) begin
          errors++; $display("FAIL il_beat%0d got en=%b wr=%b a=%h want 1/%b/%h", b, mem_en, mem_wr, mem_addr, pat[b-1], eaddr);
        end
        if (pat[b-1]) begin
          checks++;
          if (mem_wdata !== 16'h1234) begin
            errors++; $display("FAIL il_wdata%0d got %h want 1234", b, mem_wdata);
          end
        end
      end
      if (c == 8) begin
        checks++;
        if (mem_en !== 1'b0) begin
          errors++; $display("FAIL il_idle got %b want 0", mem_en);
        end
      end
      erdy = 2'b00;
      eaddr = 14'h0;
      case (c)
        5: begin erdy = 2'b01; eaddr = 14'h0102; end
        7: begin erdy = 2'b01; eaddr = 14'h0104; end
        8: begin erdy = 2'b01; eaddr = 14'h0105; end
        default: ;
      endcase
      checks++;
      if (data_out_ready !== erdy) begin
        errors++; $display("FAIL il_rdy c=%0d got %b want %b", c, data_out_ready, erdy);
      end
      if (erdy != 2'b00) begin
        checks++;
        if (data_out !== f(eaddr)) begin
          errors++; $display("FAIL il_data c=%0d got %h want %h", c, data_out, f(eaddr));
        end
      end
      if (c <= 6) begin
        wr[0] = pat[c-1];
        a0 = pat[c-1] ? 14'h0005 : 14'(14'h0100 + c);
      end else begin
        req = 2'b00;
      end
    end
  endtask

  task automatic test_reset_flush();
    int nrdy;
    nrdy = 0;
    reset_dut();
    req = 2'b01; wr = 2'b01; a0 = 14'h0011; a1 = 14'h0020;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 3) begin
        checks++;
        if (gnt !== 2'b10) begin
          errors++; $display("FAIL rf_handover got %b want 10", gnt);
        end
      end
      if (c == 5) begin
        checks++;
        if (gnt !== 2'b00 || mem_en !== 1'b0 || data_out !== 16'h0) begin
          errors++; $display("FAIL rf_in_reset got %b/%b/%h want 00/0/0", gnt, mem_en, data_out);
        end
        checks++;
        if (dut.ptr_q !== 1'b0) begin
          errors++; $display("FAIL rf_ptr got %b want 0", dut.ptr_q);
        end
      end
      if (c == 7) begin
        checks++;
        if (gnt !== 2'b01) begin
          errors++; $display("FAIL rf_restart got %b want 01", gnt);
        end
      end
      if (c >= 4 && data_out_ready !== 2'b00) nrdy++;
      case (c)
        2: req = 2'b10;
        4: begin reset = 1'b1; req = 2'b00; end
        6: begin reset = 1'b0; req = 2'b11; wr = 2'b00; end
        7: req = 2'b00;
        default: ;
      endcase
    end
    checks++;
    if (nrdy != 0) begin
      errors++; $display("FAIL rf_flush got %0d returns want 0", nrdy);
    end
  endtask

  task automatic test_drop_switch();
    reset_dut();
    req = 2'b11; wr = 2'b00; a0 = 14'h0030; a1 = 14'h0031;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 4) begin
        checks++;
        if (gnt !== 2'b01 || mem_addr !== 14'h0030) begin
          errors++; $display("FAIL ds_hold got %b/%h want 01/0030", gnt, mem_addr);
        end
      end
      if (c == 5) begin
        checks++;
        if (gnt !== 2'b10 || mem_en !== 1'b0) begin
          errors++; $display("FAIL ds_switch got %b/%b want 10/0", gnt, mem_en);
        end
        checks++;
        if (dut.ptr_q !== 1'b1) begin
          errors++; $display("FAIL ds_ptr got %b want 1", dut.ptr_q);
        end
      end
      if (c == 6) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 14'h0031) begin
          errors++; $display("FAIL ds_next got %b/%h want 1/0031", mem_en, mem_addr);
        end
      end
      if (c == 4) req = 2'b10;
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_sole_requester();
    test_interleave();
    test_reset_flush();
    test_drop_switch();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_scheduler.md
MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 14, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-003 SHALL have parameter PERIPHERALS, default 2, requester count (legal range 1..8).
REQ-004 SHALL have parameter BURST_MAX, default 8, maximum consecutive beats per grant (legal range 1..64).
REQ-005 SHALL have parameter READ_LATENCY, default 2, cycles from mem_en to valid mem_rdata (legal range 1..4).
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk  in  1  single system clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 req  in  PERIPHERALS  per-requester access request, level.
REQ-010 wr  in  PERIPHERALS  per-requester direction; 1 = write, 0 = read.
REQ-011 address  in  ADDRESS_WIDTH*PERIPHERALS  packed addresses; requester i at slice i.
REQ-012 data_in  in  DATA_WIDTH*PERIPHERALS  packed write data; requester i at slice i.
REQ-013 gnt  out  PERIPHERALS  registered one-hot grant, or all-zero.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_wr  out  1  memory write enable; qualified by mem_en.
REQ-016 mem_addr  out  ADDRESS_WIDTH  memory address.
REQ-017 mem_wdata  out  DATA_WIDTH  memory write data.
REQ-018 mem_rdata  in  DATA_WIDTH  memory read data.
REQ-019 data_out  out  DATA_WIDTH  shared read-return bus.
REQ-020 data_out_ready  out  PERIPHERALS  one-cycle read-return strobe, at most one bit set.

Function
REQ-021 A beat SHALL be accepted in any cycle where req[i] and gnt[i] are both 1; inputs of non-granted requesters are ignored.
REQ-022 States SHALL be IDLE (gnt = 0) and GRANT (gnt one-hot); beat counter and round-robin pointer are kept.
REQ-023 IDLE: if any req is set, the first requester at or after the pointer, searching upward with wrap, SHALL be granted next cycle; state GRANT; counter 0.
REQ-024 GRANT: each accepted beat SHALL increment the counter.
REQ-025 Release SHALL occur when req of the grantee is 0, or when the accepted beat is beat BURST_MAX; the pointer becomes grantee+1 mod PERIPHERALS.
REQ-026 On release, the next grantee SHALL be selected from the updated pointer in the same cycle, with no idle bubble.
REQ-027 The former grantee SHALL be eligible only as lowest priority, so a sole requester is regranted immediately.
REQ-028 If no requester remains on release, state SHALL be IDLE.
REQ-029 mem_en, mem_wr, mem_addr and mem_wdata SHALL be registered copies of the beat accepted at cycle T, driven at T+1.
REQ-030 In non-accept cycles mem_en and mem_wr SHALL be 0 while mem_addr and mem_wdata hold.
REQ-031 For a read accepted at T, data_out SHALL carry mem_rdata and data_out_ready[i] SHALL pulse at T+1+READ_LATENCY.
REQ-032 Read returns SHALL be tracked through a requester-ID/valid shift pipeline of depth READ_LATENCY; back-to-back reads SHALL return one per cycle, in order.
REQ-033 Writes SHALL never produce data_out_ready.
REQ-034 With PERIPHERALS = 1, gnt[0] SHALL stay high while req[0] is held, and the counter SHALL wrap at BURST_MAX without a bubble.

Reset
REQ-035 While reset is 1: gnt = 0, mem_en = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0, data_out = 0, data_out_ready = 0, pointer = 0, counter = 0, state IDLE.
REQ-036 Reset SHALL flush the read pipeline; reads in flight before reset SHALL produce no data_out_ready after reset.

Structure
REQ-037 The state enum and the default width constants SHALL live in shared package led_ctrl_pkg.
REQ-038 The round-robin search SHALL be one sub-module, rr_priority_picker: inputs request vector and pointer; output one-hot pick and valid.

Verification
REQ-039 P=2, req=2'b01 (read, addr 0x0010) held 3 cycles -> gnt=01 one cycle later; mem_en pulses 3x at addr 0x0010; data_out_ready[0] pulses 3x, first at accept+3.
REQ-040 req=2'b11 held continuously, BURST_MAX=8 -> gnt alternates 01/10 every 8 beats with no zero cycle between grants.
REQ-041 Sole requester 1 holds req for 20 beats, BURST_MAX=8 -> gnt[1] stays high; 20 mem_en pulses; no bubble.
REQ-042 Interleaved writes (0x1234 to 0x0005) and reads -> mem_wr=1 only on write beats; data_out_ready only on read beats; returns in order.
REQ-043 Reset asserted 1 cycle after a read accept -> no data_out_ready during or after reset; gnt=0; pointer restarts at requester 0.
REQ-044 Requester 0 drops req after beat 3 while requester 1 is pending -> gnt switches to 10 the next cycle; pointer = 1.
